// File: rtl/jtframe_pll_rst_seq_if.sv
// Signal bundle between the PLL reset sequencer and its surroundings.
// The master side drives lock/init/soft-reset inputs; the slave is the sequencer.
interface jtframe_pll_rst_seq_if;
    logic       pll_locked;
    logic       sdram_init_done;
    logic       soft_rst;
    logic       sdram_init;
    logic       game_rst;
    logic       ready;
    logic       lock_lost;
    logic [7:0] loss_cnt;
    logic [2:0] st;

    modport master (
        output pll_locked,
        output sdram_init_done,
        output soft_rst,
        input  sdram_init,
        input  game_rst,
        input  ready,
        input  lock_lost,
        input  loss_cnt,
        input  st
    );

    modport slave (
        input  pll_locked,
        input  sdram_init_done,
        input  soft_rst,
        output sdram_init,
        output game_rst,
        output ready,
        output lock_lost,
        output loss_cnt,
        output st
    );
endinterface

// File: rtl/jtframe_pll_rst_seq.sv
// Ordered bring-up after PLL lock: stable-lock wait, SDRAM init, reset hold.
// Any lock loss restarts the sequence and is logged once lock had been used.
module jtframe_pll_rst_seq #(
    parameter int LOCK_W = 16,
    parameter int HOLD_W = 10
)(
    input  logic clk,
    input  logic rst,
    jtframe_pll_rst_seq_if.slave bus
);

    localparam logic [2:0] WAIT_LOCK = 3'd0;
    localparam logic [2:0] STABLE    = 3'd1;
    localparam logic [2:0] SDINIT    = 3'd2;
    localparam logic [2:0] HOLD      = 3'd3;
    localparam logic [2:0] RUN       = 3'd4;

    logic [1:0]        sync;
    logic              locked_s;
    logic [2:0]        st_q;
    logic [2:0]        st_nx;
    logic [LOCK_W-1:0] lock_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              hold_done;
    logic              inited;
    logic              lost;
    logic              count_loss;
    logic              game_rst_q;
    logic              sdram_init_q;
    logic              ready_q;
    logic              lock_lost_q;
    logic [7:0]        loss_cnt_q;

    assign locked_s   = sync[1];
    assign lost       = !locked_s && (st_q != WAIT_LOCK);
    assign count_loss = lost && (inited || (st_q != STABLE));

    always_comb begin
        st_nx = st_q;
        if (lost) begin
            st_nx = WAIT_LOCK;
        end else begin
            unique case (1'b1)
                (st_q == WAIT_LOCK): if (locked_s) st_nx = STABLE;
                (st_q == STABLE):    if (&lock_cnt) st_nx = SDINIT;
                (st_q == SDINIT):    if (bus.sdram_init_done) st_nx = HOLD;
                (st_q == HOLD):      if (hold_done) st_nx = RUN;
                (st_q == RUN):       if (bus.soft_rst) st_nx = HOLD;
                default:             st_nx = WAIT_LOCK;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync         <= 2'b00;
            st_q         <= WAIT_LOCK;
            lock_cnt     <= '0;
            hold_cnt     <= '0;
            hold_done    <= 1'b0;
            inited       <= 1'b0;
            game_rst_q   <= 1'b1;
            sdram_init_q <= 1'b0;
            ready_q      <= 1'b0;
            lock_lost_q  <= 1'b0;
            loss_cnt_q   <= 8'd0;
        end else begin
            sync         <= {sync[0], bus.pll_locked};
            st_q         <= st_nx;
            lock_cnt     <= (st_q == STABLE) ? lock_cnt + 1'b1 : '0;
            hold_cnt     <= (st_q == HOLD) ? hold_cnt + 1'b1 : '0;
            // terminal-count flag adds one cycle: HOLD lasts 2^HOLD_W+1
            hold_done    <= (st_q == HOLD) && (&hold_cnt);
            inited       <= inited | (st_q == SDINIT);
            game_rst_q   <= (st_nx != RUN);
            sdram_init_q <= (st_nx == SDINIT);
            ready_q      <= (st_nx == RUN);
            if (count_loss) begin
                lock_lost_q <= 1'b1;
                if (loss_cnt_q != 8'hff) loss_cnt_q <= loss_cnt_q + 8'd1;
            end
        end
    end

    assign bus.st         = st_q;
    assign bus.game_rst   = game_rst_q;
    assign bus.sdram_init = sdram_init_q;
    assign bus.ready      = ready_q;
    assign bus.lock_lost  = lock_lost_q;
    assign bus.loss_cnt   = loss_cnt_q;

endmodule

// File: tb/tb_jtframe_pll_rst_seq.sv
// Vector-table bench for the PLL reset sequencer.
// LOCK_W=4, HOLD_W=3; inputs before an edge, outputs after.
module tb_jtframe_pll_rst_seq;

  typedef struct {
    logic       rst;
    logic       lk;
    logic       dn;
    logic       sr;
    logic [2:0] st;
    logic       gr;
    logic       si;
    logic       rdy;
    logic       ll;
    logic [7:0] lc;
    string      tag;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  vec_t tbl[$];
  logic       ll_e = 1'b0;
  logic [7:0] lc_e = 8'd0;
  int n_vec = 0;
  int n_err = 0;

  jtframe_pll_rst_seq_if bus();

  jtframe_pll_rst_seq #(
    .LOCK_W(4),
    .HOLD_W(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic add(
    input logic r, input logic lk,
    input logic dn, input logic sr,
    input logic [2:0] s, input string tag
  );
    vec_t v;
    v.rst = r; v.lk = lk;
    v.dn = dn; v.sr = sr;
    v.st  = s;
    v.gr  = (s != 3'd4);
    v.si  = (s == 3'd2);
    v.rdy = (s == 3'd4);
    v.ll  = ll_e;
    v.lc  = lc_e;
    v.tag = tag;
    tbl.push_back(v);
  endtask

  task automatic note_loss();
    ll_e = 1'b1;
    if (lc_e != 8'hff) lc_e = lc_e + 8'd1;
  endtask

  task automatic to_sdinit(input string tag);
    add(0, 1, 0, 0, 0, tag);
    add(0, 1, 0, 0, 0, tag);
    repeat (16) add(0, 1, 0, 0, 1, tag);
    add(0, 1, 0, 0, 2, tag);
  endtask

  task automatic finish_up(
    input int dly, input string tag
  );
    repeat (dly - 1) add(0, 1, 0, 0, 2, tag);
    add(0, 1, 1, 0, 3, tag);
    repeat (8) add(0, 1, 0, 0, 3, tag);
    add(0, 1, 0, 0, 4, tag);
  endtask

  task automatic build();
    add(1, 0, 0, 0, 0, "reset");
    add(1, 0, 0, 0, 0, "reset");
    add(0, 1, 0, 0, 0, "glitch_pre");
    add(0, 1, 0, 0, 0, "glitch_pre");
    repeat (11)
      add(0, 1, 0, 0, 1, "glitch_pre");
    add(0, 0, 0, 0, 1, "glitch");
    add(0, 0, 0, 0, 1, "glitch");
    add(0, 0, 0, 0, 0, "glitch");
    to_sdinit("bringup");
    finish_up(5, "bringup");
    add(0, 1, 1, 0, 4, "done_ignored");
    add(0, 1, 0, 0, 4, "run");
    add(0, 1, 0, 1, 3, "soft_rst");
    repeat (3)
      add(0, 1, 0, 1, 3, "soft_held");
    repeat (5)
      add(0, 1, 0, 0, 3, "soft_hold");
    add(0, 1, 0, 0, 4, "soft_run");
    add(0, 1, 0, 0, 4, "soft_run");
    add(0, 0, 0, 0, 4, "run_loss");
    add(0, 0, 0, 0, 4, "run_loss");
    note_loss();
    add(0, 0, 0, 0, 0, "run_loss");
    add(0, 0, 0, 0, 0, "run_loss");
    to_sdinit("relock");
    finish_up(5, "relock");
    add(0, 1, 0, 0, 4, "relock_run");
    add(0, 0, 0, 0, 4, "simul_run");
    add(0, 0, 0, 0, 4, "simul_run");
    note_loss();
    add(0, 0, 0, 1, 0, "simul_run");
    add(0, 0, 0, 0, 0, "simul_run");
    to_sdinit("simul_sd");
    add(0, 0, 0, 0, 2, "simul_sd");
    add(0, 0, 0, 0, 2, "simul_sd");
    note_loss();
    add(0, 0, 1, 0, 0, "simul_sd");
    add(0, 0, 0, 0, 0, "simul_sd");
    repeat (260) begin
      add(0, 1, 0, 0, 0, "sat");
      add(0, 1, 0, 0, 0, "sat");
      add(0, 1, 0, 0, 1, "sat");
      add(0, 0, 0, 0, 1, "sat");
      add(0, 0, 0, 0, 1, "sat");
      note_loss();
      add(0, 0, 0, 0, 0, "sat");
    end
    to_sdinit("pre_rst");
    add(0, 1, 1, 0, 3, "pre_rst");
    add(0, 1, 0, 0, 3, "pre_rst");
    add(0, 1, 0, 0, 3, "pre_rst");
    ll_e = 1'b0;
    lc_e = 8'd0;
    add(1, 1, 0, 0, 0, "rst_mid_hold");
    add(1, 1, 0, 0, 0, "rst_mid_hold");
    to_sdinit("post_rst");
    finish_up(3, "post_rst");
    add(0, 1, 0, 0, 4, "post_rst_run");
  endtask

  initial begin
    #100000;
    n_err++;
    $display("FAIL timeout after %0d of %0d vectors",
             n_vec, tbl.size());
    $finish;
  end

  initial begin
    rst = 1'b1;
    bus.pll_locked = 1'b0;
    bus.sdram_init_done = 1'b0;
    bus.soft_rst = 1'b0;
    build();
    @(posedge clk);
    #1;
    if (bus.st !== 3'd0 ||
        bus.game_rst !== 1'b1 ||
        bus.sdram_init !== 1'b0 ||
        bus.ready !== 1'b0 ||
        bus.lock_lost !== 1'b0 ||
        bus.loss_cnt !== 8'd0) begin
      n_err++;
      $display("FAIL reset state: st=%0d gr=%b si=%b rdy=%b ll=%b lc=%0d",
               bus.st, bus.game_rst, bus.sdram_init,
               bus.ready, bus.lock_lost, bus.loss_cnt);
    end
    foreach (tbl[i]) begin
      rst = tbl[i].rst;
      bus.pll_locked = tbl[i].lk;
      bus.sdram_init_done = tbl[i].dn;
      bus.soft_rst = tbl[i].sr;
      @(posedge clk);
      #1;
      n_vec++;
      if (bus.st !== tbl[i].st ||
          bus.game_rst !== tbl[i].gr ||
          bus.sdram_init !== tbl[i].si ||
          bus.ready !== tbl[i].rdy ||
          bus.lock_lost !== tbl[i].ll ||
          bus.loss_cnt !== tbl[i].lc) begin
        n_err++;
        $display("FAIL %s vec %0d: got st=%0d gr=%b si=%b rdy=%b ll=%b lc=%0d want st=%0d gr=%b si=%b rdy=%b ll=%b lc=%0d",
                 tbl[i].tag, i, bus.st, bus.game_rst,
                 bus.sdram_init, bus.ready,
                 bus.lock_lost, bus.loss_cnt,
                 tbl[i].st, tbl[i].gr, tbl[i].si,
                 tbl[i].rdy, tbl[i].ll, tbl[i].lc);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    if (n_err == 0) $display("PASS");
    else $display("FAIL");
    $finish;
  end

endmodule
